mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares one single-port instruction/data memory bus between the instruction-fetch requester and the MEM-stage load/store requester.
Only one transaction is outstanding on the bus at a time, with variable slave latency. Data accesses take priority over fetches, with a bounded-starvation guard for fetch.
A stall request to the pipeline controller is raised while either requester is waiting. The block sits between the core top level and the external memory bus.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width (byte-select width is DATA_W/8)
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
TIMEOUT, 255, cycles in GRANT without bus_ack_i before the transaction is aborted

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous and active-low
if_req_i  in  1  fetch request, held until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_rdata_o  out  DATA_W  fetch read data, valid when if_ack_o
if_ack_o  out  1  one-cycle fetch completion pulse
d_req_i  in  1  data request, held until d_ack_o
d_we_i  in  1  1=write, 0=read
d_sel_i  in  DATA_W/8  byte selects
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_rdata_o  out  DATA_W  load data, valid when d_ack_o
d_ack_o  out  1  one-cycle data completion pulse
err_o  out  1  pulses with the ack of a timed-out transaction
bus_req_o  out  1  bus request, registered
bus_we_o  out  1  bus write enable
bus_sel_o  out  DATA_W/8  bus byte selects
bus_addr_o  out  ADDR_W  bus address
bus_wdata_o  out  DATA_W  bus write data
bus_rdata_i  in  DATA_W  bus read data, sampled on bus_ack_i
bus_ack_i  in  1  slave completion
stallreq_o  out  1  pipeline stall request

Behaviour:
- Reset (rst=0, asynchronous) drives every output to 0, sets state=IDLE, streak=0 and timer=0. Reset mid-transaction abandons it with no ack.
- FSM states: IDLE, GRANT_IF, GRANT_D, DONE.
- IDLE: arbitrate on the current-cycle requests.
  - Pick D if d_req_i=1, unless if_req_i=1 and streak==MAX_D_STREAK, in which case pick IF.
  - Otherwise pick IF if if_req_i=1.
  - On a pick, at the next edge: go to GRANT_x, register bus_req_o=1 and bus_addr/we/sel/wdata from the winner (fetch: we=0, sel=all ones, wdata=0), clear timer.
- Streak update:
  - D grant: streak increments, saturating at MAX_D_STREAK.
  - IF grant: streak clears to 0.
  - Streak is unchanged in IDLE with no requests.
- GRANT_x: bus outputs are held stable; timer increments each cycle.
  - On bus_ack_i=1: capture bus_rdata_i into the winner's rdata_o (reads only; on a write, d_rdata_o keeps its prior value). Deassert bus_req_o, pulse the winner's ack_o high in DONE, go to DONE.
  - On timer==TIMEOUT with no ack: same path, but rdata_o=0 and err_o=1 with the ack.
- DONE: lasts one cycle, during which requests are ignored; then go to IDLE.
  - The requester must deassert req (or present a new transaction) by the cycle after its ack.
  - Minimum transaction time is 3 cycles from req to ack with a zero-wait slave (ack in first GRANT cycle).
- bus_ack_i outside GRANT is ignored.
- rdata_o holds its value until the next completion for that requester.
- stallreq_o is combinational: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). It is 0 during reset.
- Simultaneous requests in IDLE obey the priority rule; the loser stays pending and is reconsidered in the next IDLE.

Test Plan:
- Single fetch, zero-wait slave: if_req_i=1, addr=0x100, bus_ack_i in the first GRANT cycle with rdata=0x3C010101 -> bus_req_o=1 for 1 cycle with addr=0x100, we=0; if_ack_o pulses 3 cycles after req with if_rdata_o=0x3C010101; stallreq_o=1 until the ack cycle.
- Data write with 2 wait states: d_we=1, sel=4'b0011, addr=0x2000, wdata=0xAABBCCDD -> bus signals stable for 3 GRANT cycles; d_ack_o pulses once; d_rdata_o unchanged.
- Simultaneous requests, streak 0: d_req and if_req both high -> D granted first, IF granted in the next IDLE.
- Starvation guard: d_req continuously re-issued while if_req stays high, MAX_D_STREAK=4 -> 4 D grants, then IF grant, then streak=0 and D resumes.
- Timeout: GRANT_D with no bus_ack_i for 255 cycles -> d_ack_o=1, err_o=1, d_rdata_o=0; FSM returns to IDLE.
- Async reset mid-GRANT: rst low asynchronously -> bus_req_o and all acks drop immediately; after release, a fresh fetch completes normally with streak=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single-port memory bus: data beats fetch, fetch gets a forced
// grant after MAX_D_STREAK back-to-back data grants, one transaction in flight with timeout.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_ack_o,
    output logic                err_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_o
);

    localparam int STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int TIMER_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [STREAK_W-1:0]  streak_reg;
    logic [TIMER_W-1:0]   timer_reg;

    logic pick_d;
    logic pick_if;
    logic timed_out;
    logic finish;

    // Data wins unless a waiting fetch has already sat out a full data streak.
    always_comb begin
        pick_d    = d_req_i && !(if_req_i && (streak_reg == STREAK_MAX));
        pick_if   = if_req_i && !pick_d;
        timed_out = (timer_reg == TIMER_MAX);
        finish    = bus_ack_i || timed_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_d) begin
                    state_next = GRANT_D;
                end else if (pick_if) begin
                    state_next = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_D: begin
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_reg  <= '0;
            timer_reg   <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            if_ack_o    <= 1'b0;
            d_rdata_o   <= '0;
            d_ack_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            err_o    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_d) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= d_we_i;
                        bus_sel_o   <= d_sel_i;
                        bus_addr_o  <= d_addr_i;
                        bus_wdata_o <= d_wdata_i;
                        timer_reg   <= '0;
                        if (streak_reg != STREAK_MAX) begin
                            streak_reg <= streak_reg + STREAK_W'(1);
                        end
                    end else if (pick_if) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= '1;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        timer_reg   <= '0;
                        streak_reg  <= '0;
                    end
                end
                GRANT_IF, GRANT_D: begin
                    if (finish) begin
                        bus_req_o <= 1'b0;
                        err_o     <= !bus_ack_i;
                        if (state_reg == GRANT_IF) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
                        end else begin
                            d_ack_o <= 1'b1;
                            // A completed write leaves the last load data in place.
                            if (!bus_ack_i) begin
                                d_rdata_o <= '0;
                            end else if (!bus_we_o) begin
                                d_rdata_o <= bus_rdata_i;
                            end
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stallreq_o = rst & ((if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o));

endmodule
